// File: rtl/pill_dose_scheduler.sv
// rtl/pill_dose_scheduler.sv - multi-pill dose interval countdown, due/missed tracking and next-pill selection
module pill_dose_scheduler #(
  parameter int NUM_PILLS   = 3,
  parameter int TIME_WIDTH  = 17,
  parameter int GRACE_TICKS = 300,
  parameter int MISS_WIDTH  = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            loadEn,
  input  logic [IDX_WIDTH-1:0]            loadIndex,
  input  logic [TIME_WIDTH-1:0]           loadInterval,
  input  logic                            start,
  input  logic                            pause,
  input  logic [NUM_PILLS-1:0]            takenAck,
  output logic                            running,
  output logic [NUM_PILLS-1:0]            dueFlags,
  output logic [NUM_PILLS-1:0]            missedFlags,
  output logic [NUM_PILLS*MISS_WIDTH-1:0] missedCounts,
  output logic [IDX_WIDTH-1:0]            nextPillIndex,
  output logic [TIME_WIDTH-1:0]           nextPillRemaining,
  output logic                            nextPillValid
);

  localparam int GRACE_WIDTH = $clog2(GRACE_TICKS + 1);
  localparam logic [GRACE_WIDTH-1:0] GRACE_INIT = GRACE_WIDTH'(GRACE_TICKS);
  localparam logic [MISS_WIDTH-1:0]  MISS_MAX   = '1;

  typedef enum logic [1:0] {DISABLED, COUNTING, DUE} chanState_t;

  chanState_t             chanState     [NUM_PILLS];
  chanState_t             chanStateNext [NUM_PILLS];
  logic [TIME_WIDTH-1:0]  interval      [NUM_PILLS];
  logic [TIME_WIDTH-1:0]  intervalNext  [NUM_PILLS];
  logic [TIME_WIDTH-1:0]  remaining     [NUM_PILLS];
  logic [TIME_WIDTH-1:0]  remainingNext [NUM_PILLS];
  logic [GRACE_WIDTH-1:0] grace         [NUM_PILLS];
  logic [GRACE_WIDTH-1:0] graceNext     [NUM_PILLS];

  logic                            runningNext;
  logic                            tickEn;
  logic [NUM_PILLS-1:0]            dueNext;
  logic [NUM_PILLS-1:0]            missedNext;
  logic [NUM_PILLS*MISS_WIDTH-1:0] countsNext;
  logic                            nextValidNext;
  logic [IDX_WIDTH-1:0]            nextIndexNext;
  logic [TIME_WIDTH-1:0]           nextRemNext;

  always_comb begin
    runningNext = running;
    if (start) runningNext = 1'b1;
    if (pause) runningNext = 1'b0;
    tickEn     = tick && running;
    dueNext    = dueFlags;
    missedNext = missedFlags;
    countsNext = missedCounts;

    for (int i = 0; i < NUM_PILLS; i++) begin
      chanStateNext[i] = chanState[i];
      intervalNext[i]  = interval[i];
      remainingNext[i] = remaining[i];
      graceNext[i]     = grace[i];

      // Out-of-range indices never match any channel, so those loads fall through.
      if (loadEn && !running && int'(loadIndex) == i) begin
        intervalNext[i]  = loadInterval;
        remainingNext[i] = loadInterval;
        chanStateNext[i] = (loadInterval != '0) ? COUNTING : DISABLED;
        dueNext[i]       = 1'b0;
        missedNext[i]    = 1'b0;
        graceNext[i]     = '0;
      end else begin
        case (chanState[i])
          COUNTING: begin
            if (tickEn) begin
              if (remaining[i] > TIME_WIDTH'(1)) begin
                remainingNext[i] = remaining[i] - TIME_WIDTH'(1);
              end else begin
                remainingNext[i] = '0;
                chanStateNext[i] = DUE;
                dueNext[i]       = 1'b1;
                graceNext[i]     = GRACE_INIT;
              end
            end
          end
          DUE: begin
            // Ack is checked first so it beats an expiring grace tick.
            if (takenAck[i]) begin
              dueNext[i]       = 1'b0;
              missedNext[i]    = 1'b0;
              remainingNext[i] = interval[i];
              graceNext[i]     = '0;
              chanStateNext[i] = COUNTING;
            end else if (tickEn) begin
              if (grace[i] > GRACE_WIDTH'(1)) begin
                graceNext[i] = grace[i] - GRACE_WIDTH'(1);
              end else begin
                missedNext[i]    = 1'b1;
                dueNext[i]       = 1'b0;
                remainingNext[i] = interval[i];
                graceNext[i]     = '0;
                chanStateNext[i] = COUNTING;
                if (missedCounts[i*MISS_WIDTH +: MISS_WIDTH] != MISS_MAX)
                  countsNext[i*MISS_WIDTH +: MISS_WIDTH] =
                    missedCounts[i*MISS_WIDTH +: MISS_WIDTH] + MISS_WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    // Strict less-than keeps the lowest index on ties.
    nextValidNext = 1'b0;
    nextIndexNext = '0;
    nextRemNext   = '0;
    for (int i = 0; i < NUM_PILLS; i++) begin
      if (chanState[i] == COUNTING && (!nextValidNext || remaining[i] < nextRemNext)) begin
        nextValidNext = 1'b1;
        nextIndexNext = IDX_WIDTH'(i);
        nextRemNext   = remaining[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running           <= 1'b0;
      dueFlags          <= '0;
      missedFlags       <= '0;
      missedCounts      <= '0;
      nextPillValid     <= 1'b0;
      nextPillIndex     <= '0;
      nextPillRemaining <= '0;
      for (int i = 0; i < NUM_PILLS; i++) begin
        chanState[i] <= DISABLED;
        interval[i]  <= '0;
        remaining[i] <= '0;
        grace[i]     <= '0;
      end
    end else begin
      running           <= runningNext;
      dueFlags          <= dueNext;
      missedFlags       <= missedNext;
      missedCounts      <= countsNext;
      nextPillValid     <= nextValidNext;
      nextPillIndex     <= nextIndexNext;
      nextPillRemaining <= nextRemNext;
      for (int i = 0; i < NUM_PILLS; i++) begin
        chanState[i] <= chanStateNext[i];
        interval[i]  <= intervalNext[i];
        remaining[i] <= remainingNext[i];
        grace[i]     <= graceNext[i];
      end
    end
  end

endmodule

// File: tb/tb_pill_dose_scheduler.sv
// tb/tb_pill_dose_scheduler.sv - directed self-checking bench for pill_dose_scheduler (GRACE_TICKS=2)
module tb_pill_dose_scheduler;

  localparam int NP = 3;
  localparam int TW = 17;
  localparam int MW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          loadEn = 1'b0;
  logic [IW-1:0] loadIndex = '0;
  logic [TW-1:0] loadInterval = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [NP-1:0] takenAck = '0;
  logic          running;
  logic [NP-1:0] dueFlags;
  logic [NP-1:0] missedFlags;
  logic [NP*MW-1:0] missedCounts;
  logic [IW-1:0] nextPillIndex;
  logic [TW-1:0] nextPillRemaining;
  logic          nextPillValid;

  int vectors = 0;
  int miscompares = 0;

  pill_dose_scheduler #(
    .NUM_PILLS(NP), .TIME_WIDTH(TW), .GRACE_TICKS(2), .MISS_WIDTH(MW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .loadEn(loadEn), .loadIndex(loadIndex),
    .loadInterval(loadInterval), .start(start), .pause(pause), .takenAck(takenAck),
    .running(running), .dueFlags(dueFlags), .missedFlags(missedFlags),
    .missedCounts(missedCounts), .nextPillIndex(nextPillIndex),
    .nextPillRemaining(nextPillRemaining), .nextPillValid(nextPillValid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doLoad(input int idx, input int val);
    loadEn = 1'b1;
    loadIndex = IW'(idx);
    loadInterval = TW'(val);
    cyc();
    loadEn = 1'b0;
  endtask

  task automatic doTick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic doPause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_running", 32'(running), 0);
    chk("rst_due", 32'(dueFlags), 0);
    chk("rst_counts", 32'(missedCounts), 0);
    chk("rst_valid", 32'(nextPillValid), 0);
    reset = 1'b0;
    cyc();

    // Reset mid-count
    doLoad(0, 5);
    doStart();
    chk("mid_running", 32'(running), 1);
    doTick();
    doTick();
    chk("mid_next_lag", 32'(nextPillRemaining), 4);
    #2 reset = 1'b1;
    #1;
    chk("async_running", 32'(running), 0);
    chk("async_valid", 32'(nextPillValid), 0);
    chk("async_rem", 32'(nextPillRemaining), 0);
    #1 reset = 1'b0;
    cyc();

    // Basic due / ack
    doLoad(1, 3);
    doStart();
    doTick();
    doTick();
    doTick();
    chk("due_flags", 32'(dueFlags), 32'b010);
    chk("due_next_lag", 32'(nextPillRemaining), 1);
    cyc();
    chk("due_none_counting", 32'(nextPillValid), 0);
    takenAck = 3'b010;
    cyc();
    takenAck = '0;
    chk("ack_due", 32'(dueFlags), 0);
    cyc();
    chk("ack_rem", 32'(nextPillRemaining), 3);
    chk("ack_idx", 32'(nextPillIndex), 1);
    doPause();
    doLoad(1, 0);

    // Miss path
    doLoad(0, 1);
    doStart();
    doTick();
    chk("miss_due", 32'(dueFlags), 32'b001);
    doTick();
    doTick();
    chk("miss_flag", 32'(missedFlags), 32'b001);
    chk("miss_count1", 32'(missedCounts), 32'h001);
    chk("miss_due_clr", 32'(dueFlags), 0);
    for (int k = 0; k < 14; k++) begin
      doTick();
      doTick();
      doTick();
    end
    chk("miss_count15", 32'(missedCounts), 32'h00F);
    doTick();
    doTick();
    doTick();
    chk("miss_saturate", 32'(missedCounts), 32'h00F);
    chk("miss_flag_sat", 32'(missedFlags), 32'b001);

    // Ack / miss collision on pill2
    doPause();
    doLoad(0, 0);
    chk("load_keeps_count", 32'(missedCounts), 32'h00F);
    doLoad(2, 1);
    doStart();
    doTick();
    chk("col_due", 32'(dueFlags), 32'b100);
    doTick();
    tick = 1'b1;
    takenAck = 3'b100;
    cyc();
    tick = 1'b0;
    takenAck = '0;
    chk("col_due_clr", 32'(dueFlags), 0);
    chk("col_missed", 32'(missedFlags), 0);
    chk("col_counts", 32'(missedCounts), 32'h00F);
    cyc();
    chk("col_valid", 32'(nextPillValid), 1);
    chk("col_idx", 32'(nextPillIndex), 2);
    chk("col_rem", 32'(nextPillRemaining), 1);

    // Next-pill selection with a tie
    doPause();
    doLoad(0, 10);
    doLoad(1, 4);
    doLoad(2, 4);
    doStart();
    cyc();
    chk("np_idx", 32'(nextPillIndex), 1);
    chk("np_rem", 32'(nextPillRemaining), 4);
    doTick();
    cyc();
    chk("np_rem_tick", 32'(nextPillRemaining), 3);
    doPause();
    doLoad(0, 0);
    doLoad(1, 0);
    doLoad(2, 0);
    cyc();
    chk("np_none_valid", 32'(nextPillValid), 0);
    chk("np_none_idx", 32'(nextPillIndex), 0);
    chk("np_none_rem", 32'(nextPillRemaining), 0);

    // Control edges
    start = 1'b1;
    pause = 1'b1;
    cyc();
    start = 1'b0;
    pause = 1'b0;
    chk("start_pause", 32'(running), 0);
    doLoad(0, 5);
    doStart();
    doLoad(0, 2);
    cyc();
    chk("load_running_ign", 32'(nextPillRemaining), 5);
    doPause();
    doTick();
    cyc();
    chk("tick_paused", 32'(nextPillRemaining), 5);
    doLoad(3, 1);
    cyc();
    chk("idx3_ign_idx", 32'(nextPillIndex), 0);
    chk("idx3_ign_rem", 32'(nextPillRemaining), 5);
    doStart();
    for (int k = 0; k < 5; k++) doTick();
    chk("interval_due", 32'(dueFlags), 32'b001);
    takenAck = 3'b001;
    cyc();
    takenAck = '0;
    cyc();
    chk("interval_kept", 32'(nextPillRemaining), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pill_dose_scheduler.md
Name: pill_dose_scheduler

Overview:
Parametrised multi-pill dose scheduler; successor to the fixed three-pill next-pill/LED logic of the prescription reminder. Holds a programmable dose interval per pill and counts each down on a one-second tick. It flags doses as due, then as missed if no acknowledgement arrives within a grace window, and keeps a saturating missed-dose count per pill. It also reports the soonest upcoming pill for the LCD and seven-segment paths. It sits between the Control/Clock blocks (tick, load, start/pause) and the LED/LCD drivers.

Parameters:
NUM_PILLS, 3, number of independent pill channels (>=1)
TIME_WIDTH, 17, width of interval/remaining counters in seconds (17 covers 24 h)
GRACE_TICKS, 300, ticks a dose may stay due before it is declared missed (>=1)
MISS_WIDTH, 4, width of each per-pill missed counter
IDX_WIDTH, 2, width of pill index ports (>= clog2(NUM_PILLS), min 1)

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle pulse per counted second; demo/real rate is chosen upstream
loadEn  input  1  write loadInterval into channel loadIndex
loadIndex  input  IDX_WIDTH  channel selected for load
loadInterval  input  TIME_WIDTH  dose interval in ticks; 0 disables the channel
start  input  1  begin or resume counting
pause  input  1  stop counting
takenAck  input  NUM_PILLS  per-pill "pill taken" pulse
running  output  1  scheduler counting
dueFlags  output  NUM_PILLS  dose currently due
missedFlags  output  NUM_PILLS  sticky "last dose missed" flag
missedCounts  output  NUM_PILLS*MISS_WIDTH  per-pill missed counts; pill i at [i*MISS_WIDTH +: MISS_WIDTH]
nextPillIndex  output  IDX_WIDTH  counting pill with smallest remaining time
nextPillRemaining  output  TIME_WIDTH  remaining ticks of that pill
nextPillValid  output  1  at least one pill is counting

Behaviour:
- Reset (async, mid-operation included): all intervals, remaining, grace counters, flags, counts, running, and next* outputs are 0. All channels go to DISABLED.
- All outputs are registered. Effects of inputs sampled at edge N are visible after edge N.
- Global run state: start sets running=1 and pause clears it. If both are high in the same cycle, pause wins. tick is ignored while running=0.
- Each channel has three states: DISABLED, COUNTING and DUE.
- loadEn is honoured only when running=0. Loads with running=1 or loadIndex>=NUM_PILLS are ignored. A load does the following:
  - interval[i] and remaining[i] take loadInterval.
  - The channel goes to COUNTING if loadInterval is nonzero, otherwise DISABLED.
  - dueFlags[i], missedFlags[i] and the grace counter are cleared. missedCounts[i] is unchanged.
- COUNTING, on tick while running:
  - If remaining>1, remaining decrements.
  - If remaining==1, remaining becomes 0, the channel goes to DUE, dueFlags[i]=1, and grace is set to GRACE_TICKS.
- DUE, on tick while running:
  - If grace>1, grace decrements.
  - If grace==1, the dose is missed: missedFlags[i]=1, missedCounts[i] increments (saturating at all-ones), dueFlags[i]=0, remaining=interval, and the channel returns to COUNTING.
- takenAck[i] while DUE is accepted in any cycle, running or paused. Its effect: dueFlags[i]=0, missedFlags[i]=0, remaining=interval, and the channel returns to COUNTING. takenAck in COUNTING or DISABLED is ignored.
- If takenAck and the expiring tick arrive in the same cycle, the ack wins: no miss is recorded.
- Channels are fully independent. Any number of them may become due or missed on the same tick.
- Next-pill selection:
  - Considers only COUNTING channels and picks the minimum remaining; ties go to the lowest index.
  - It is registered from the current state, so it lags the counters by one cycle.
  - With no COUNTING channel: nextPillValid=0, nextPillIndex=0, nextPillRemaining=0.
- Arithmetic: counters are unsigned. remaining never underflows and never exceeds interval.

Test Plan:
- Reset mid-count: pill0 loaded with 5, started, 2 ticks, reset asserted -> all outputs 0 immediately (asynchronously), running=0.
- Basic due/ack: load pill1=3, start, 3 ticks -> dueFlags=3'b010 after the 3rd tick. Then takenAck[1] -> dueFlags=0 and pill1 remaining=3.
- Miss path with GRACE_TICKS=2: load pill0=1, start. Tick 1 -> due. Tick 3 -> missedFlags[0]=1, missedCounts[0]=1, dueFlags[0]=0. Repeat 16 misses -> count saturates at 15.
- Ack/miss collision: pill due with grace=1, takenAck and tick in the same cycle -> missedCounts unchanged, missedFlags=0, channel counting.
- Next-pill: load pills with 10/4/4, start -> nextPillIndex=1, nextPillRemaining=4. Disable all (load 0 while paused) -> nextPillValid=0.
- Control edges: start+pause in the same cycle -> running=0. loadEn while running -> interval unchanged. Tick while paused -> no decrement. loadIndex=3 with NUM_PILLS=3 -> ignored.
